// File: rtl/mult_pkg.sv
// Shared widths and FSM state encoding for the sequential 16x16 multiplier.
package mult_pkg;

    localparam int HALF_W = 8;
    localparam int FULL_W = 16;
    localparam int PROD_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } state_e;

endpackage

// File: rtl/mult16_seq_accum_mult8.sv
// Combinational 8x8 -> 16 unsigned multiplier core shared across the partial-product states.
module EightBitMult
    import mult_pkg::*;
(
    input  logic [HALF_W-1:0] M,
    input  logic [HALF_W-1:0] Q,
    output logic [FULL_W-1:0] c
);

    assign c = M * Q;

endmodule

// File: rtl/mult16_seq_accum.sv
// Sequential 16x16 unsigned multiplier: four byte partial products through one 8x8 core,
// shifted and accumulated into a 32-bit product with valid/ready on both sides.
module mult16_seq_accum
    import mult_pkg::*;
#(
    parameter int HALF      = 8,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FULL_W-1:0] M,
    input  logic [FULL_W-1:0] Q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] P,
    output logic              busy
);

    if (HALF != HALF_W) begin : g_bad_half
        $error("mult16_seq_accum: HALF must be 8");
    end

    state_e              state_q, state_d;
    logic [FULL_W-1:0]   m_q, m_d;
    logic [FULL_W-1:0]   q_q, q_d;
    logic [PROD_W-1:0]   acc_q, acc_d;

    logic [HALF_W-1:0]   core_a, core_b;
    logic [FULL_W-1:0]   core_c;
    logic [PROD_W-1:0]   pp_ext;

    EightBitMult u_mult8 (
        .M (core_a),
        .Q (core_b),
        .c (core_c)
    );

    // Operands only ever come from the registered copies, never from the live ports.
    always_comb begin
        core_a = '0;
        core_b = '0;
        unique case (state_q)
            PP0: begin core_a = m_q[HALF_W-1:0];      core_b = q_q[HALF_W-1:0];      end
            PP1: begin core_a = m_q[FULL_W-1:HALF_W]; core_b = q_q[HALF_W-1:0];      end
            PP2: begin core_a = m_q[HALF_W-1:0];      core_b = q_q[FULL_W-1:HALF_W]; end
            PP3: begin core_a = m_q[FULL_W-1:HALF_W]; core_b = q_q[FULL_W-1:HALF_W]; end
            default: ;
        endcase
    end

    assign pp_ext = {{(PROD_W-FULL_W){1'b0}}, core_c};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d   = M;
                    q_d   = Q;
                    acc_d = '0;
                    if (SKIP_ZERO && ((M == '0) || (Q == '0)))
                        state_d = DONE;
                    else
                        state_d = PP0;
                end
            end
            PP0: begin
                acc_d   = acc_q + pp_ext;
                state_d = PP1;
            end
            PP1: begin
                acc_d   = acc_q + (pp_ext << HALF_W);
                state_d = PP2;
            end
            PP2: begin
                acc_d   = acc_q + (pp_ext << HALF_W);
                state_d = PP3;
            end
            PP3: begin
                acc_d   = acc_q + (pp_ext << FULL_W);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
        end
    end

    // P is gated so a partially accumulated value is never visible.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign P         = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_mult16_seq_accum.sv
// Directed bench for mult16_seq_accum: latency, products, backpressure, operand isolation,
// mid-operation reset and the zero-operand bypass.
module tb_mult16_seq_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid1;
    logic        in_ready, in_ready1;
    logic [15:0] M, Q;
    logic        out_valid, out_valid1;
    logic        out_ready, out_ready1;
    logic [31:0] P, P1;
    logic        busy, busy1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mult16_seq_accum #(.HALF(8), .SKIP_ZERO(1'b0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .Q         (Q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    mult16_seq_accum #(.HALF(8), .SKIP_ZERO(1'b1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .M         (M),
        .Q         (Q),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .P         (P1),
        .busy      (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction on dut0 with out_ready=1. The cycle after the accept edge is
    // "edge T+1"; out_valid first seen before edge T+lat.
    task automatic do_op(input logic [15:0] m, input logic [15:0] q,
                         input logic [31:0] exp_p, input int exp_lat, input string tag);
        int k;
        M         = m;
        Q         = q;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_lat"}, k + 1, exp_lat);
        chk({tag, "_p"}, P, exp_p);
        tick();
    endtask

    initial begin
        logic [15:0] rm, rq;
        logic [31:0] held_p;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_valid1  = 1'b0;
        out_ready  = 1'b0;
        out_ready1 = 1'b0;
        M          = '0;
        Q          = '0;
        @(negedge clk);

        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_p",         P,         0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: detailed timing of 1*2
        M = 16'h0001; Q = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_busy",      busy,     1);
        chk("t1_in_ready0", in_ready, 0);
        tick(); tick(); tick();
        chk("t1_not_yet",   out_valid, 0);
        chk("t1_p_hidden",  P,         0);
        tick();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_p",         P,         32'h0000_0002);
        tick();
        chk("t1_in_ready",  in_ready,  1);
        chk("t1_ov_clear",  out_valid, 0);

        // Test 2: corner and reference vectors
        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5, "t2_ffff");
        do_op(16'h1234, 16'h5678, 32'h0626_0060, 5, "t2_1234");
        do_op(16'h8000, 16'h0002, 32'h0001_0000, 5, "t2_carry");
        do_op(16'h0100, 16'h0100, 32'h0001_0000, 5, "t2_hi_hi");

        for (int i = 0; i < 1000; i++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            do_op(rm, rq, {16'h0, rm} * {16'h0, rq}, 5, "t2_rand");
        end

        // Test 3: backpressure, in_valid pulses while stalled
        M = 16'h1234; Q = 16'h5678; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t3_valid", out_valid, 1);
        held_p = P;
        chk("t3_p", held_p, 32'h0626_0060);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            M = 16'(i * 16'h1111);
            Q = 16'hFFFF - 16'(i);
            tick();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_p",     P,         32'h0626_0060);
            chk("t3_in_ready",   in_ready,  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_release_idle", in_ready,  1);
        chk("t3_release_ov",   out_valid, 0);
        tick();
        chk("t3_no_accept",    busy,      0);

        // Test 4: live operands scrambled while the product is being built
        M = 16'hBEEF; Q = 16'h1357; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            M = 16'($urandom);
            Q = 16'($urandom);
            tick();
        end
        chk("t4_valid", out_valid, 1);
        chk("t4_p",     P,         32'd241999929);
        tick();

        // Test 5: asynchronous reset during PP2
        M = 16'hAAAA; Q = 16'h5555; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_in_ready", in_ready,  1);
        chk("t5_ov",       out_valid, 0);
        chk("t5_busy",     busy,      0);
        chk("t5_p",        P,         0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(16'h00FF, 16'h0100, 32'h0000_FF00, 5, "t5_after");

        // Test 6: zero operand with and without the bypass
        M = 16'h0000; Q = 16'hABCD; in_valid1 = 1'b1; out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("t6_skip_valid", out_valid1, 1);
        chk("t6_skip_p",     P1,         0);
        tick();
        chk("t6_skip_idle",  in_ready1,  1);
        do_op(16'h0000, 16'hABCD, 32'h0, 5, "t6_noskip");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
